// File: rtl/gray_wptr_full.sv
// Write-domain side of the async FIFO pointer path: binary/Gray write pointer,
// read-pointer synchronizer, registered full flag and conservative fill level.
module gray_wptr_full #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gray_async,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int unsigned P = ADDR_WIDTH + 1;
    // Full when the write Gray pointer equals the read Gray pointer with its two MSBs inverted
    localparam logic [P-1:0] TOP_MASK = P'(3) << (P - 2);

    logic [P-1:0] wbin_q,  wbin_d;
    logic [P-1:0] wgray_q, wgray_d;
    logic         full_q,  full_d;
    logic [P-1:0] rsync_q [SYNC_STAGES];
    logic [P-1:0] rsync_d [SYNC_STAGES];
    logic [P-1:0] rq;
    logic [P-1:0] rbin;

    assign rq = rsync_q[SYNC_STAGES-1];

    // Next-state pointers, synchronizer shift and full compare
    always_comb begin
        wr_accept  = wr_en & ~full_q & ~rst;
        wbin_d     = wbin_q + P'(wr_accept);
        wgray_d    = wbin_d ^ (wbin_d >> 1);
        rsync_d[0] = rd_gray_async;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            rsync_d[i] = rsync_q[i-1];
        end
        full_d = (wgray_d == (rq ^ TOP_MASK));
    end

    // Gray-to-binary: each bit is the XOR of itself and all higher bits
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i < P; i++) begin
            rbin[i] = ^(rq >> i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            rsync_q <= '{default: '0};
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            rsync_q <= rsync_d;
        end
    end

    assign wr_addr  = wbin_q[ADDR_WIDTH-1:0];
    assign wr_gray  = wgray_q;
    assign full     = full_q;
    assign wr_level = wbin_q - rbin;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Bench for gray_wptr_full: occupancy-arithmetic model checked every cycle,
// plus directed fill/overflow/drain/wrap/reset scenarios with literal expectations.
module tb_gray_wptr_full;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] rd_g;
    logic       wr_accept;
    logic [3:0] wr_addr;
    logic [4:0] wr_gray;
    logic       full;
    logic [4:0] wr_level;

    gray_wptr_full #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .rd_gray_async (rd_g),
        .wr_accept     (wr_accept),
        .wr_addr       (wr_addr),
        .wr_gray       (wr_gray),
        .full          (full),
        .wr_level      (wr_level)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [4:0] gray(input int n);
        int t;
        t = n & 31;
        return 5'(t ^ (t >> 1));
    endfunction

    // Decode by search: the n whose Gray code matches
    function automatic int g2b(input int g);
        for (int n = 0; n < 32; n++) begin
            if (int'(gray(n)) == g) return n;
        end
        return -1;
    endfunction

    // Model: number of entries written (mod 32) and the read pointers seen through a delay line
    int  m_w     = 0;
    bit  m_full  = 1'b0;
    bit  m_valid = 1'b0;
    int  m_q[$];

    always @(posedge clk) begin : model
        int acc;
        int nw;
        if (rst) begin
            m_w    = 0;
            m_full = 1'b0;
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            acc    = (wr_en && !m_full) ? 1 : 0;
            nw     = (m_w + acc) & 31;
            m_full = (((nw - g2b(m_q[$])) & 31) == 16);
            m_q.push_front(int'(rd_g));
            void'(m_q.pop_back());
            m_w = nw;
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            chk("gray",   int'(wr_gray),   int'(gray(m_w)));
            chk("addr",   int'(wr_addr),   m_w & 15);
            chk("full",   int'(full),      m_full ? 1 : 0);
            chk("level",  int'(wr_level),  (m_w - g2b(m_q[$])) & 31);
            chk("accept", int'(wr_accept), (wr_en && !m_full && !rst) ? 1 : 0);
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [4:0] g);
        rst   = r;
        wr_en = w;
        rd_g  = g;
        @(negedge clk);
        #1;
    endtask

    logic [4:0] prev_g;
    bit         saw_wrap;
    int         rp;
    logic       rr;

    initial begin
        rst = 1'b1; wr_en = 1'b1; rd_g = 5'b10101;

        // Reset held with write requested and a nonzero read pointer
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 5'b10101);
            chk("rst_gray",   int'(wr_gray),   0);
            chk("rst_addr",   int'(wr_addr),   0);
            chk("rst_full",   int'(full),      0);
            chk("rst_level",  int'(wr_level),  0);
            chk("rst_accept", int'(wr_accept), 0);
        end

        // Fill 16 entries with the reader parked at 0
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 5'b00000);
            if (i == 15) chk("fill15_full", int'(full), 0);
        end
        chk("fill_full",  int'(full),     1);
        chk("fill_gray",  int'(wr_gray),  24);
        chk("fill_level", int'(wr_level), 16);
        chk("fill_addr",  int'(wr_addr),  0);

        // Writes while full are dropped
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 5'b00000);
            chk("ovf_accept", int'(wr_accept), 0);
            chk("ovf_gray",   int'(wr_gray),   24);
            chk("ovf_level",  int'(wr_level),  16);
        end

        // One read becomes visible through the synchronizer
        cyc(1'b0, 1'b0, 5'b00001);
        chk("drain_e1_full", int'(full), 1);
        cyc(1'b0, 1'b0, 5'b00001);
        chk("drain_e2_full",  int'(full),     1);
        chk("drain_e2_level", int'(wr_level), 15);
        cyc(1'b0, 1'b0, 5'b00001);
        chk("drain_e3_full", int'(full), 0);
        wr_en = 1'b1;
        #1;
        chk("drain_accept", int'(wr_accept), 1);
        cyc(1'b0, 1'b1, 5'b00001);
        chk("drain_wr_gray", int'(wr_gray), 25);
        chk("drain_refull",  int'(full),    1);

        // Reader catches up to 4 behind, then stream 40 writes across the wrap
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, gray(13));
        chk("track_level", int'(wr_level), 4);
        prev_g   = wr_gray;
        saw_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, gray((m_w - 4) & 31));
            chk("wrap_full", int'(full), 0);
            chk("wrap_hd",   $countones(wr_gray ^ prev_g), 1);
            if (prev_g == 5'b10000) begin
                saw_wrap = 1'b1;
                chk("wrap_gray0", int'(wr_gray), 0);
                chk("wrap_addr0", int'(wr_addr), 0);
            end
            prev_g = wr_gray;
        end
        chk("wrap_seen", int'(saw_wrap), 1);
        chk("wrap_end",  int'(wr_gray),  int'(gray(25)));

        // Reset in the middle of a fill
        cyc(1'b1, 1'b0, 5'b00000);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 5'b00000);
        chk("mid_gray7", int'(wr_gray), 4);
        chk("mid_addr7", int'(wr_addr), 7);
        cyc(1'b1, 1'b1, 5'b00000);
        chk("mid_rst_gray",   int'(wr_gray),   0);
        chk("mid_rst_addr",   int'(wr_addr),   0);
        chk("mid_rst_level",  int'(wr_level),  0);
        chk("mid_rst_full",   int'(full),      0);
        chk("mid_rst_accept", int'(wr_accept), 0);
        cyc(1'b0, 1'b1, 5'b00000);
        chk("post_rst_gray1", int'(wr_gray), 1);
        cyc(1'b0, 1'b1, 5'b00000);
        cyc(1'b0, 1'b1, 5'b00000);
        chk("post_rst_gray3",  int'(wr_gray),  2);
        chk("post_rst_level3", int'(wr_level), 3);

        // Random writes, reads bounded by occupancy, occasional reset
        rp = 0;
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            if (rr) rp = 0;
            else if ((((m_w - rp) & 31) != 0) && ($urandom_range(0, 1) == 1)) rp = (rp + 1) & 31;
            cyc(rr, ($urandom_range(0, 9) < 7), gray(rp));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
